// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side blocks: output-queue FSM encoding
// and statistics counter width.
package fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    localparam int unsigned STATS_W = 16;

endpackage

// File: rtl/fifo_rd_stream.sv
// Read-side stream adapter: turns the FIFO rempty/rinc/rdata interface into a
// valid/ready stream through a 2-entry queue. FIFO_RD_STREAM_STATS_EN adds a pop counter.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = 8
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 rempty,
    input  logic [DATA_SIZE-1:0] rdata,
    output logic                 rinc,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef FIFO_RD_STREAM_STATS_EN
    output logic [STATS_W-1:0]   out_count,
`endif
    output logic [DATA_SIZE-1:0] out_data
);

    state_e               state_q;
    logic [DATA_SIZE-1:0] head_q;
    logic [DATA_SIZE-1:0] tail_q;
    logic                 load;
    logic                 pop;

    // Request depends only on registered state, so out_ready never reaches rinc.
    always_comb begin
        load = !rempty && (state_q != TWO) && !rrst;
        pop  = (state_q != EMPTY) && out_ready;
    end

    assign rinc      = load;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = head_q;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (load) begin
                        head_q  <= rdata;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (load && pop) begin
                        head_q  <= rdata;
                    end else if (load) begin
                        tail_q  <= rdata;
                        state_q <= TWO;
                    end else if (pop) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_q  <= tail_q;
                        state_q <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [STATS_W-1:0] count_q;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            count_q <= '0;
        end else if (pop && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign out_count = count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed self-checking bench for fifo_rd_stream; inputs change on the falling
// edge and everything is observed 1 time unit later.
`timescale 1ns/1ps
module tb_fifo_rd_stream;
    import fifo_pkg::*;

    logic       rclk = 1'b0;
    logic       rrst;
    logic       rempty;
    logic [7:0] rdata;
    logic       rinc;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [STATS_W-1:0] out_count;
`endif

    int errors = 0;
    int checks = 0;

    fifo_rd_stream #(.DATA_SIZE(8)) dut (
        .rclk     (rclk),
        .rrst     (rrst),
        .rempty   (rempty),
        .rdata    (rdata),
        .rinc     (rinc),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef FIFO_RD_STREAM_STATS_EN
        .out_count(out_count),
`endif
        .out_data (out_data)
    );

    always #5 rclk = ~rclk;

    // Advance to the next falling edge, apply inputs, let combinational paths settle.
    task automatic drive(input logic rst, input logic emp, input logic [7:0] d, input logic rdy);
        @(negedge rclk);
        rrst = rst; rempty = emp; rdata = d; out_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 8'h5A, 1'b1);
            if (rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc%0d: got %b want 0", i, rinc); end
            checks++;
        end
        drive(1'b0, 1'b1, 8'h5A, 1'b0);
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++;
        if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", out_data); end
        checks++;
`ifdef FIFO_RD_STREAM_STATS_EN
        if (out_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", out_count); end
        checks++;
`endif
    endtask

    task automatic test_streaming();
        logic [7:0] words [3];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        drive(1'b0, 1'b0, words[0], 1'b1);
        if (rinc !== 1'b1) begin errors++; $display("FAIL stream_rinc0: got %b want 1", rinc); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_valid0: got %b want 0", out_valid); end
        checks++;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, (i == 2), (i < 2) ? words[i+1] : 8'h00, 1'b1);
            if (out_valid !== 1'b1 || out_data !== words[i]) begin
                errors++; $display("FAIL stream_word%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, words[i]);
            end
            checks++;
            if (rinc !== (i < 2)) begin errors++; $display("FAIL stream_rinc%0d: got %b want %b", i + 1, rinc, (i < 2)); end
            checks++;
        end
        drive(1'b0, 1'b1, 8'h00, 1'b1);
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end_valid: got %b want 0", out_valid); end
        checks++;
    endtask

    task automatic test_backpressure();
        drive(1'b0, 1'b0, 8'h41, 1'b0);
        if (rinc !== 1'b1) begin errors++; $display("FAIL bp_load1: got %b want 1", rinc); end
        checks++;
        drive(1'b0, 1'b0, 8'h42, 1'b0);
        if (rinc !== 1'b1) begin errors++; $display("FAIL bp_load2: got %b want 1", rinc); end
        checks++;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 8'h43, 1'b0);
            if (rinc !== 1'b0) begin errors++; $display("FAIL bp_full_rinc%0d: got %b want 0", i, rinc); end
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h41) begin
                errors++; $display("FAIL bp_hold%0d: got v=%b d=%h want v=1 d=41", i, out_valid, out_data);
            end
            checks++;
        end
        drive(1'b0, 1'b0, 8'h43, 1'b1);
        if (rinc !== 1'b0) begin errors++; $display("FAIL bp_two_ready_rinc: got %b want 0", rinc); end
        checks++;
        drive(1'b0, 1'b0, 8'h43, 1'b1);
        if (out_data !== 8'h42) begin errors++; $display("FAIL bp_second: got %h want 42", out_data); end
        checks++;
        if (rinc !== 1'b1) begin errors++; $display("FAIL bp_resume: got %b want 1", rinc); end
        checks++;
        drive(1'b0, 1'b1, 8'h00, 1'b1);
        if (out_data !== 8'h43) begin errors++; $display("FAIL bp_third: got %h want 43", out_data); end
        checks++;
        drive(1'b0, 1'b1, 8'h00, 1'b1);
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid: got %b want 0", out_valid); end
        checks++;
    endtask

    task automatic test_drain();
        drive(1'b0, 1'b0, 8'hA5, 1'b1);
        drive(1'b0, 1'b1, 8'h00, 1'b1);
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            errors++; $display("FAIL drain_word: got v=%b d=%h want v=1 d=a5", out_valid, out_data);
        end
        checks++;
        if (rinc !== 1'b0) begin errors++; $display("FAIL drain_rinc: got %b want 0", rinc); end
        checks++;
        drive(1'b0, 1'b1, 8'h00, 1'b1);
        if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", out_valid); end
        checks++;
    endtask

    task automatic test_reset_in_two();
        drive(1'b0, 1'b0, 8'h61, 1'b0);
        drive(1'b0, 1'b0, 8'h62, 1'b0);
        drive(1'b0, 1'b0, 8'h63, 1'b0);
        if (out_valid !== 1'b1 || rinc !== 1'b0) begin
            errors++; $display("FAIL two_state: got v=%b rinc=%b want v=1 rinc=0", out_valid, rinc);
        end
        checks++;
        drive(1'b1, 1'b0, 8'h63, 1'b1);
        if (rinc !== 1'b0) begin errors++; $display("FAIL two_rst_rinc: got %b want 0", rinc); end
        checks++;
        drive(1'b0, 1'b1, 8'h00, 1'b1);
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++; $display("FAIL two_rst_state: got v=%b d=%h want v=0 d=00", out_valid, out_data);
        end
        checks++;
`ifdef FIFO_RD_STREAM_STATS_EN
        if (out_count !== 16'd0) begin errors++; $display("FAIL two_rst_count: got %0d want 0", out_count); end
        checks++;
`endif
    endtask

`ifdef FIFO_RD_STREAM_STATS_EN
    task automatic test_stats();
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 8'(i), 1'b1);
        drive(1'b0, 1'b1, 8'h00, 1'b1);
        drive(1'b0, 1'b1, 8'h00, 1'b1);
        if (out_count !== 16'd5) begin errors++; $display("FAIL stats_five: got %0d want 5", out_count); end
        checks++;
        @(negedge rclk);
        force dut.count_q = 16'hFFFD;
        #1;
        release dut.count_q;
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'(i), 1'b1);
        drive(1'b0, 1'b1, 8'h00, 1'b1);
        drive(1'b0, 1'b1, 8'h00, 1'b1);
        if (out_count !== 16'hFFFF) begin errors++; $display("FAIL stats_sat: got %h want ffff", out_count); end
        checks++;
    endtask
`endif

    initial begin
        rrst = 1'b1; rempty = 1'b1; rdata = '0; out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_drain();
        test_reset_in_two();
`ifdef FIFO_RD_STREAM_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
